psum_drain: RTL and testbench

- Consumer at the tail of the conv-kernel psum adder chain.
- Watches the registered psum stream and counts accumulation steps per output window.
- On the last step of each window, captures the final psum, right-shifts it arithmetically, saturates it to the output width, and buffers it in a small FIFO.
- The buffered result streams out on a valid/ready interface toward the output buffer, and a done pulse marks the end of a job.

---
 rtl/psum_drain.sv | 152 +++++++++++++++
 tb/tb_psum_drain.sv | 251 +++++++++++++++++++++++++
 2 files changed

// File: rtl/psum_drain.sv
// Tail consumer of the psum adder chain: counts accumulation steps per
// output window, shifts/saturates each final psum and queues it in a small
// first-word fall-through FIFO that drains over a valid/ready port.
module psum_drain #(
    parameter int DWIDTH     = 32,
    parameter int ODWIDTH    = 16,
    parameter int CNTW       = 16,
    parameter int FIFO_DEPTH = 4
) (
    input  logic                      clk,
    input  logic                      rstn,
    input  logic                      start,
    input  logic [CNTW-1:0]           cfg_acc_len,
    input  logic [CNTW-1:0]           cfg_num_win,
    input  logic [4:0]                cfg_shift,
    input  logic                      psum_vld,
    input  logic signed [DWIDTH-1:0]  psum_data,
    output logic                      out_vld,
    input  logic                      out_rdy,
    output logic signed [ODWIDTH-1:0] out_data,
    output logic                      busy,
    output logic                      done,
    output logic                      ovf_err
);

    localparam int AW = $clog2(FIFO_DEPTH);
    localparam logic signed [DWIDTH-1:0] OMAX = DWIDTH'(2 ** (ODWIDTH - 1) - 1);
    localparam logic signed [DWIDTH-1:0] OMIN = ~OMAX;

    typedef enum logic [1:0] {IDLE, ACC, DRAIN, DONE} state_t;

    state_t                     state;
    logic [CNTW-1:0]            acc_len, num_win, acc_cnt, win_cnt;
    logic [4:0]                 shift;

    logic signed [ODWIDTH-1:0]  mem [FIFO_DEPTH];
    logic [AW-1:0]              wptr, rptr;
    logic [AW:0]                count;

    logic                       full, empty, pop, push_req, push_ok;
    logic                       last_smp, last_win;
    logic signed [DWIDTH-1:0]   shifted;
    logic signed [ODWIDTH-1:0]  result;

    assign empty    = (count == '0);
    assign full     = (count == (AW+1)'(FIFO_DEPTH));
    assign pop      = !empty && out_rdy;
    assign last_smp = (acc_cnt == acc_len - 1'b1);
    assign last_win = (win_cnt == num_win - 1'b1);
    assign push_req = (state == ACC) && psum_vld && last_smp;
    // A full FIFO still takes the push when the head leaves in the same cycle.
    assign push_ok  = push_req && (!full || pop);

    assign out_vld  = !empty;
    assign out_data = empty ? '0 : mem[rptr];

    // Truncating arithmetic shift, then clamp into the signed output range.
    always_comb begin
        shifted = psum_data >>> shift;
        if (shifted > OMAX)
            result = OMAX[ODWIDTH-1:0];
        else if (shifted < OMIN)
            result = OMIN[ODWIDTH-1:0];
        else
            result = shifted[ODWIDTH-1:0];
    end

    // FIFO storage; contents are don't-care until written, so no reset.
    always_ff @(posedge clk) begin
        if (push_ok)
            mem[wptr] <= result;
    end

    // FIFO pointers and occupancy; pointers wrap naturally at FIFO_DEPTH.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            wptr  <= '0;
            rptr  <= '0;
            count <= '0;
        end else begin
            if (push_ok) wptr <= wptr + 1'b1;
            if (pop)     rptr <= rptr + 1'b1;
            case ({push_ok, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: ;
            endcase
        end
    end

    // Job sequencing, window counting and the sticky overflow flag.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state   <= IDLE;
            acc_len <= '0;
            num_win <= '0;
            shift   <= '0;
            acc_cnt <= '0;
            win_cnt <= '0;
            busy    <= 1'b0;
            done    <= 1'b0;
            ovf_err <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        acc_len <= cfg_acc_len;
                        num_win <= cfg_num_win;
                        shift   <= cfg_shift;
                        acc_cnt <= '0;
                        win_cnt <= '0;
                        ovf_err <= 1'b0;
                        busy    <= 1'b1;
                        if (cfg_acc_len == '0 || cfg_num_win == '0) begin
                            state <= DONE;
                            done  <= 1'b1;
                        end else begin
                            state <= ACC;
                        end
                    end
                end
                ACC: begin
                    if (psum_vld) begin
                        if (!last_smp) begin
                            acc_cnt <= acc_cnt + 1'b1;
                        end else begin
                            acc_cnt <= '0;
                            if (last_win) state <= DRAIN;
                            else          win_cnt <= win_cnt + 1'b1;
                        end
                    end
                end
                DRAIN: begin
                    if (empty) begin
                        state <= DONE;
                        done  <= 1'b1;
                    end
                end
                DONE: begin
                    state <= IDLE;
                    done  <= 1'b0;
                    busy  <= 1'b0;
                end
                default: state <= IDLE;
            endcase
            // Only ACC can request a push, so this never races the start clear.
            if (push_req && !push_ok)
                ovf_err <= 1'b1;
        end
    end

endmodule

// File: tb/tb_psum_drain.sv
// Directed bench for psum_drain: hand-computed windows, shift/saturation,
// back-pressure, overflow, full-with-pop and reset/start corner cases.
module tb_psum_drain;

    logic               clk;
    logic               rstn;
    logic               start;
    logic [15:0]        cfg_acc_len;
    logic [15:0]        cfg_num_win;
    logic [4:0]         cfg_shift;
    logic               psum_vld;
    logic signed [31:0] psum_data;
    logic               out_vld;
    logic               out_rdy;
    logic signed [15:0] out_data;
    logic               busy;
    logic               done;
    logic               ovf_err;

    int vectors = 0;
    int miscompares = 0;

    psum_drain #(.DWIDTH(32), .ODWIDTH(16), .CNTW(16), .FIFO_DEPTH(4)) dut (
        .clk(clk), .rstn(rstn), .start(start),
        .cfg_acc_len(cfg_acc_len), .cfg_num_win(cfg_num_win), .cfg_shift(cfg_shift),
        .psum_vld(psum_vld), .psum_data(psum_data),
        .out_vld(out_vld), .out_rdy(out_rdy), .out_data(out_data),
        .busy(busy), .done(done), .ovf_err(ovf_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic signed [31:0] got,
                       input logic signed [31:0] exp);
        vectors++;
        assert (got === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic do_start(input int len, input int nw, input int sh);
        start       = 1'b1;
        cfg_acc_len = 16'(len);
        cfg_num_win = 16'(nw);
        cfg_shift   = 5'(sh);
        tick();
        start       = 1'b0;
    endtask

    task automatic send(input int v);
        psum_vld  = 1'b1;
        psum_data = v;
        tick();
        psum_vld  = 1'b0;
        psum_data = 32'sd999;
    endtask

    task automatic wait_done(input string tag, input int budget);
        int n = 0;
        while (!done && n < budget) begin
            tick();
            n++;
        end
        chk(tag, done, 1);
        tick();
        chk({tag, "_idle"}, busy, 0);
    endtask

    initial begin
        rstn = 1'b0; start = 1'b0; cfg_acc_len = '0; cfg_num_win = '0;
        cfg_shift = '0; psum_vld = 1'b0; psum_data = '0; out_rdy = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_out_vld", out_vld, 0);
        chk("rst_out_data", out_data, 0);
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_ovf", ovf_err, 0);
        rstn = 1'b1;
        tick();

        // basic window: 10,25,40 -> single beat 40
        out_rdy = 1'b1;
        do_start(3, 1, 0);
        chk("t1_busy", busy, 1);
        send(10);
        send(25);
        chk("t1_no_early_beat", out_vld, 0);
        send(40);
        chk("t1_vld", out_vld, 1);
        chk("t1_data", out_data, 40);
        tick();
        chk("t1_popped", out_vld, 0);
        chk("t1_no_done_yet", done, 0);
        tick();
        chk("t1_done", done, 1);
        chk("t1_busy_in_done", busy, 1);
        tick();
        chk("t1_done_clr", done, 0);
        chk("t1_idle", busy, 0);

        // shift and saturation
        out_rdy = 1'b0;
        do_start(1, 3, 4);
        send(32'sh0001_0000);
        send(-32'sh0010_0000);
        send(-37);
        out_rdy = 1'b1;
        chk("t2_d0", out_data, 4096);
        tick();
        chk("t2_d1_sat", out_data, -32768);
        tick();
        chk("t2_d2", out_data, -3);
        tick();
        chk("t2_empty", out_vld, 0);
        wait_done("t2_done", 10);

        // gaps and back-pressure
        out_rdy = 1'b0;
        do_start(2, 4, 0);
        send(1);   tick();
        send(100); tick();
        send(2);   tick();
        send(-200); tick();
        send(3);   tick();
        send(300); tick();
        send(4);   tick();
        send(400);
        chk("t3_head", out_data, 100);
        tick();
        chk("t3_hold", out_data, 100);
        chk("t3_hold_vld", out_vld, 1);
        chk("t3_no_done_stalled", done, 0);
        chk("t3_ovf", ovf_err, 0);
        out_rdy = 1'b1;
        tick();
        chk("t3_d1", out_data, -200);
        tick();
        chk("t3_d2", out_data, 300);
        tick();
        chk("t3_d3", out_data, 400);
        chk("t3_no_done_before_last", done, 0);
        tick();
        chk("t3_empty", out_vld, 0);
        wait_done("t3_done", 10);

        // overflow: 6 finals into a 4-deep FIFO with no drain
        out_rdy = 1'b0;
        do_start(1, 6, 0);
        for (int i = 11; i <= 14; i++) send(i);
        chk("t4_no_ovf_at_full", ovf_err, 0);
        send(15);
        chk("t4_ovf_set", ovf_err, 1);
        send(16);
        chk("t4_ovf_sticky", ovf_err, 1);
        out_rdy = 1'b1;
        chk("t4_d0", out_data, 11);
        tick();
        chk("t4_d1", out_data, 12);
        tick();
        chk("t4_d2", out_data, 13);
        tick();
        chk("t4_d3", out_data, 14);
        tick();
        chk("t4_empty", out_vld, 0);
        wait_done("t4_done", 10);
        chk("t4_ovf_after_done", ovf_err, 1);

        // full with simultaneous pop; this start also clears ovf_err
        out_rdy = 1'b0;
        do_start(1, 5, 0);
        chk("t5_ovf_cleared", ovf_err, 0);
        for (int i = 21; i <= 24; i++) send(i);
        out_rdy = 1'b1;
        send(25);
        chk("t5_ovf", ovf_err, 0);
        chk("t5_d1", out_data, 22);
        tick();
        chk("t5_d2", out_data, 23);
        tick();
        chk("t5_d3", out_data, 24);
        tick();
        chk("t5_d4", out_data, 25);
        tick();
        chk("t5_empty", out_vld, 0);
        wait_done("t5_done", 10);

        // acc_len=0 gives immediate done; start held in DONE is ignored
        start = 1'b1; cfg_acc_len = 16'd0; cfg_num_win = 16'd2; cfg_shift = 5'd0;
        tick();
        chk("t6_done", done, 1);
        chk("t6_busy", busy, 1);
        chk("t6_no_beat", out_vld, 0);
        cfg_acc_len = 16'd5; cfg_num_win = 16'd1;
        tick();
        start = 1'b0;
        chk("t6_done_clr", done, 0);
        chk("t6_start_in_done_ignored", busy, 0);

        // start while busy must not alter the latched config
        out_rdy = 1'b1;
        do_start(1, 2, 0);
        start = 1'b1; cfg_acc_len = 16'd5; cfg_num_win = 16'd1; cfg_shift = 5'd1;
        tick();
        start = 1'b0;
        chk("t7_busy", busy, 1);
        send(7);
        chk("t7_d0_vld", out_vld, 1);
        chk("t7_d0", out_data, 7);
        send(8);
        chk("t7_d1", out_data, 8);
        tick();
        chk("t7_empty", out_vld, 0);
        wait_done("t7_done", 10);

        // asynchronous reset mid-ACC with two entries queued
        out_rdy = 1'b0;
        do_start(1, 4, 0);
        send(5);
        send(6);
        chk("t8_vld_before", out_vld, 1);
        rstn = 1'b0;
        #1;
        chk("t8_vld_async", out_vld, 0);
        chk("t8_busy_async", busy, 0);
        #2;
        rstn = 1'b1;
        tick();
        chk("t8_idle", busy, 0);
        send(9);
        chk("t8_idle_ignores_psum", out_vld, 0);
        chk("t8_still_idle", busy, 0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
